serial_subtractor: RTL and testbench

//  Multi-cycle N-bit subtractor: the parametrised successor to the 1-bit half subtractor.

---
 rtl/serial_subtractor.sv | 178 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             brw_r;
    logic [CNT_W-1:0] cnt_r;

    logic             accept_s;
    logic             last_s;
    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT:0]   dig_ext_s;
    logic [DIGIT-1:0] d_s;
    logic             brw_nxt_s;
    logic [WIDTH-1:0] res_nxt_s;
    logic [WIDTH-1:0] a_nxt_s;
    logic [WIDTH-1:0] b_nxt_s;

`ifdef SUB_OVERFLOW_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ovf_nxt_s;
`endif

    assign accept_s = start & ~busy;
    assign last_s   = (cnt_r == LAST_CNT);

    // One digit of the ripple: the extra top bit of the widened difference is the new borrow.
    always_comb begin
        a_dig_s   = a_sh_r[DIGIT-1:0];
        b_dig_s   = b_sh_r[DIGIT-1:0];
        dig_ext_s = {1'b0, a_dig_s} - {1'b0, b_dig_s} - {{DIGIT{1'b0}}, brw_r};
        d_s       = dig_ext_s[DIGIT-1:0];
        brw_nxt_s = dig_ext_s[DIGIT];
        res_nxt_s = WIDTH'({d_s, res_r} >> DIGIT);
        a_nxt_s   = WIDTH'({{DIGIT{1'b0}}, a_sh_r} >> DIGIT);
        b_nxt_s   = WIDTH'({{DIGIT{1'b0}}, b_sh_r} >> DIGIT);
    end

`ifdef SUB_OVERFLOW_EN
    assign ovf_nxt_s = (a_msb_r ^ b_msb_r) & (a_msb_r ^ res_nxt_s[WIDTH-1]);
`endif

    // Next-state decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand shift registers, partial result, running borrow and digit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            res_r  <= {WIDTH{1'b0}};
            brw_r  <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
`ifdef SUB_OVERFLOW_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
`endif
        end else if (accept_s) begin
            a_sh_r <= a;
            b_sh_r <= b;
            res_r  <= {WIDTH{1'b0}};
            brw_r  <= bin;
            cnt_r  <= {CNT_W{1'b0}};
`ifdef SUB_OVERFLOW_EN
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
`endif
        end else if (state_r == ST_RUN) begin
            a_sh_r <= a_nxt_s;
            b_sh_r <= b_nxt_s;
            res_r  <= res_nxt_s;
            brw_r  <= brw_nxt_s;
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

    // Registered handshake and result outputs; results only change on the final digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            diff <= {WIDTH{1'b0}};
            bout <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf  <= 1'b0;
`endif
        end else if ((state_r == ST_RUN) && last_s) begin
            busy <= 1'b0;
            done <= 1'b1;
            diff <= res_nxt_s;
            bout <= brw_nxt_s;
`ifdef SUB_OVERFLOW_EN
            ovf  <= ovf_nxt_s;
`endif
        end else if (accept_s) begin
            busy <= 1'b1;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four instances (DIGIT 1,2,4,8 at WIDTH 8) checked through a scoreboard.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_v [4];
    logic [7:0] a_v     [4];
    logic [7:0] b_v     [4];
    logic       bin_v   [4];
    logic       busy_s  [4];
    logic       done_s  [4];
    logic [7:0] diff_s  [4];
    logic       bout_s  [4];
`ifdef SUB_OVERFLOW_EN
    logic       ovf_s   [4];
`endif

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   done_cnt [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_subtractor #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[g]),
            .a     (a_v[g]),
            .b     (b_v[g]),
            .bin   (bin_v[g]),
            .busy  (busy_s[g]),
            .done  (done_s[g]),
            .diff  (diff_s[g]),
            .bout  (bout_s[g])
`ifdef SUB_OVERFLOW_EN
            ,
            .ovf   (ovf_s[g])
`endif
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int inst, input logic [7:0] aa, input logic [7:0] bb, input logic bi);
        logic [8:0] r;
        exp_t       e;
        r      = {1'b0, aa} - {1'b0, bb} - {8'd0, bi};
        e.inst = 2'(inst);
        e.diff = r[7:0];
        e.bout = r[8];
        e.ovf  = (aa[7] ^ bb[7]) & (aa[7] ^ r[7]);
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (done_s[i] === 1'b1) begin
                done_cnt[i]++;
                if (sb_q.size() == 0) begin
                    check_val("done_without_op", 32'(done_s[i]), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("sb_inst", 32'(i), 32'(e.inst));
                    check_val("sb_diff", 32'(diff_s[i]), 32'(e.diff));
                    check_val("sb_bout", 32'(bout_s[i]), 32'(e.bout));
`ifdef SUB_OVERFLOW_EN
                    check_val("sb_ovf", 32'(ovf_s[i]), 32'(e.ovf));
`endif
                end
            end
        end
    end

    // Wait (bounded) for done on one instance; returns cycles waited.
    task automatic wait_done(input int inst, input int n, input int glitch_at, output int lat);
        lat = 0;
        while ((done_s[inst] !== 1'b1) && (lat <= n + 4)) begin
            if (lat == glitch_at) begin
                start_v[inst] = 1'b1;
                a_v[inst]     = 8'hAA;
            end else begin
                start_v[inst] = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start_v[inst] = 1'b0;
    endtask

    task automatic run_op(input int inst, input logic [7:0] aa, input logic [7:0] bb,
                          input logic bi, input int glitch_at);
        int n, lat, dc0;
        n = 8 >> inst;
        @(negedge clk);
        start_v[inst] = 1'b1;
        a_v[inst]     = aa;
        b_v[inst]     = bb;
        bin_v[inst]   = bi;
        push_exp(inst, aa, bb, bi);
        dc0 = done_cnt[inst];
        @(negedge clk);
        start_v[inst] = 1'b0;
        a_v[inst]     = 8'($urandom);
        b_v[inst]     = 8'($urandom);
        bin_v[inst]   = 1'($urandom);
        check_val("busy_after_start", 32'(busy_s[inst]), 32'd1);
        wait_done(inst, n, glitch_at, lat);
        check_val("latency", 32'(lat), 32'(n));
        @(negedge clk);
        check_val("done_one_cycle", 32'(done_s[inst]), 32'd0);
        check_val("done_count", 32'(done_cnt[inst] - dc0), 32'd1);
    endtask

    task automatic run_b2b(input int inst, input logic [7:0] a1, input logic [7:0] b1, input logic bi1,
                           input logic [7:0] a2, input logic [7:0] b2, input logic bi2);
        int n, lat;
        n = 8 >> inst;
        @(negedge clk);
        start_v[inst] = 1'b1;
        a_v[inst]     = a1;
        b_v[inst]     = b1;
        bin_v[inst]   = bi1;
        push_exp(inst, a1, b1, bi1);
        @(negedge clk);
        start_v[inst] = 1'b0;
        wait_done(inst, n, -1, lat);
        check_val("b2b_first_latency", 32'(lat), 32'(n));
        start_v[inst] = 1'b1;
        a_v[inst]     = a2;
        b_v[inst]     = b2;
        bin_v[inst]   = bi2;
        push_exp(inst, a2, b2, bi2);
        @(negedge clk);
        start_v[inst] = 1'b0;
        check_val("b2b_busy", 32'(busy_s[inst]), 32'd1);
        wait_done(inst, n, -1, lat);
        check_val("b2b_throughput", 32'(lat + 1), 32'(n + 1));
        @(negedge clk);
    endtask

    initial begin
        int dc0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = 8'd0;
            b_v[i]     = 8'd0;
            bin_v[i]   = 1'b0;
            done_cnt[i] = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_val("rst_busy", 32'(busy_s[i]), 32'd0);
            check_val("rst_done", 32'(done_s[i]), 32'd0);
            check_val("rst_diff", 32'(diff_s[i]), 32'd0);
            check_val("rst_bout", 32'(bout_s[i]), 32'd0);
        end
        rst = 1'b0;

        // Directed cases on DIGIT=1
        run_op(0, 8'h05, 8'h03, 1'b0, -1);
        run_op(0, 8'h03, 8'h05, 1'b0, -1);
        run_op(0, 8'h00, 8'h00, 1'b1, -1);
        run_op(0, 8'h5A, 8'h5A, 1'b0, -1);
        run_op(0, 8'h05, 8'h03, 1'b0, 3);

        // Abort mid-run with reset
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 8'h05;
        b_v[0]     = 8'h03;
        bin_v[0]   = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_busy", 32'(busy_s[0]), 32'd0);
        check_val("abort_done", 32'(done_s[0]), 32'd0);
        check_val("abort_diff", 32'(diff_s[0]), 32'd0);
        check_val("abort_bout", 32'(bout_s[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dc0 = done_cnt[0];
        repeat (12) @(negedge clk);
        check_val("abort_no_done", 32'(done_cnt[0] - dc0), 32'd0);
        check_val("abort_idle", 32'(busy_s[0]), 32'd0);
        run_op(0, 8'h05, 8'h03, 1'b0, -1);

        // Wider digits, back-to-back and single-cycle compute
        run_op(2, 8'h3C, 8'h1D, 1'b0, -1);
        run_b2b(2, 8'h3C, 8'h1D, 1'b0, 8'h10, 8'h20, 1'b1);
        run_b2b(0, 8'hC8, 8'h64, 1'b1, 8'h01, 8'h02, 1'b0);
        run_b2b(3, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h0F, 1'b1);
        run_op(3, 8'h00, 8'h00, 1'b1, -1);
        run_op(1, 8'hFF, 8'hFF, 1'b0, -1);

        // Signed overflow corners
        run_op(0, 8'h80, 8'h01, 1'b0, -1);
        run_op(0, 8'h7F, 8'hFF, 1'b0, -1);
        run_op(3, 8'h80, 8'h01, 1'b0, -1);

        // Random vectors, 250 per digit size
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 250; k++) begin
                run_op(g, 8'($urandom), 8'($urandom), 1'($urandom), -1);
            end
        end

        repeat (2) @(negedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
